eu_issue_queue: RTL and testbench
=================================

# eu_issue_queue

Instruction issue queue between the fetch side and the execution unit (`eu_reg_alu`). It buffers 32-bit instruction-and-immediate words in a small FIFO and presents them to the EU through a valid/ready handshake. It supports a single-cycle flush for control transfers and keeps saturating performance counters (issued, retired, starve and back-pressure cycles) that benches and software read directly.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; power of two, ≥ 2.
- `INSTR_W`, default 32: instruction-and-immediate word width.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `fetch_valid`  in  1  fetch side offers `fetch_instr` this cycle.
- `fetch_instr`  in  INSTR_W  offered word.
- `fetch_ready`  out  1  queue can accept a word; equals `level < DEPTH`.
- `flush`  in  1  discard all queued words.
- `issue_valid`  out  1  head word is presented to the EU.
- `issue_instr`  out  INSTR_W  head word; 0 when the queue is empty.
- `issue_ready`  in  1  EU accepts the head this cycle.
- `retire`  in  1  one-cycle pulse from the EU; one instruction completed.
- `perf_clear`  in  1  synchronous clear of all four counters.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `issued_count`, `retired_count`, `starve_cycles`, `backpressure_cycles`  out  CNT_W each  performance counters.

## Operation
- Push: `fetch_valid && fetch_ready && !flush`. The word is written at `mem[wr_ptr]` and `wr_ptr` advances modulo DEPTH.
- Pop: `issue_valid && issue_ready`. `rd_ptr` advances modulo DEPTH.
- `issue_valid = (level != 0) && !flush`. `issue_instr = mem[rd_ptr]` when `level != 0`, else 0.
- Simultaneous push and pop: `level` is unchanged and both pointers advance. This is legal at any non-full level, including level 1.
- No bypass: a push into an empty queue is not visible on `issue_*` in the same cycle.
- `fetch_ready` is low when full, even if a pop occurs in the same cycle. A push attempted while not ready is ignored and the word is lost; holding `fetch_valid` is the producer's responsibility.
- Flush: on the next edge, `level`, `wr_ptr` and `rd_ptr` go to 0. A push in the flush cycle is dropped. No pop occurs in the flush cycle because `issue_valid` is forced low. Counters are not affected, except `starve_cycles`, which follows its normal rule.
- Counters: each one increments by 1 per qualifying cycle and saturates at all-ones.
  - `issued_count`: one per pop.
  - `retired_count`: one per `retire` cycle.
  - `starve_cycles`: one per cycle with `issue_ready && !issue_valid`.
  - `backpressure_cycles`: one per cycle with `issue_valid && !issue_ready`.
- `perf_clear` takes priority over increment; counters read 0 after the edge.
- `retire` is not checked against `issued_count`.

## Timing
- Reset values: `level` = 0, pointers = 0, all counters = 0, `issue_valid` = 0, `issue_instr` = 0, `fetch_ready` = 1.
- Reset is asserted asynchronously, released synchronously to `clk` by the environment, and may occur mid-stream; queued words are discarded.
- Latency: a word pushed at edge N is on `issue_instr` with `issue_valid` = 1 after edge N; it can be popped at edge N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained.
- All outputs except `issue_valid`, which depends combinationally on `flush`, are functions of registered state.
- `issue_instr` is stable while `issue_valid && !issue_ready`.

## Structure
- Package `eu_issue_pkg` holds:
  - `INSTR_W` = 32 and the default `DEPTH`.
  - A `level_w(depth)` width function.
  - Named opcode constants used by the bench, e.g. `MOV_AL_01` = 32'h80200001, `MOV_AX_1234` = 32'h81201234.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `reset`, `clear`, `inc`, `count`), instantiated four times.
- The storage array and pointers live in `eu_issue_queue`.

## Test plan
- Reset then idle, `issue_ready` = 1 for 5 cycles → `issue_valid` = 0, `level` = 0, `starve_cycles` = 5, `fetch_ready` = 1.
- Push 32'h80200001, 32'h81201234, 32'h81211256 on consecutive cycles with `issue_ready` = 1 → words issue in order, each one cycle after its push; `issued_count` = 3; `level` returns to 0.
- `issue_ready` = 0, push 5 words with DEPTH = 4 → `fetch_ready` drops after the 4th word, the 5th is ignored, `level` = 4, `backpressure_cycles` increments every cycle; releasing `issue_ready` drains exactly 4 words in order.
- Queue at level 2, assert `flush` with `fetch_valid` = 1 and `issue_ready` = 1 → `issue_valid` = 0 that cycle, `level` = 0 next cycle, `issued_count` unchanged, pushed word not present.
- Drive `retire` for 2^CNT_W + 3 cycles → `retired_count` saturates at all-ones; `perf_clear` then zeroes all counters.
- Assert `reset` asynchronously mid-drain at level 3 → all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/eu_issue_pkg.sv
// Shared widths, defaults and opcode constants for the EU issue queue.
package eu_issue_pkg;

  localparam int unsigned INSTR_W       = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned DEFAULT_CNT_W = 16;

  // Occupancy needs one extra bit so that a full queue (level == depth) is representable.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam logic [INSTR_W-1:0] MOV_AL_01   = 32'h8020_0001;
  localparam logic [INSTR_W-1:0] MOV_AX_1234 = 32'h8120_1234;
  localparam logic [INSTR_W-1:0] MOV_CX_1256 = 32'h8121_1256;
  localparam logic [INSTR_W-1:0] NOP_WORD    = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/eu_issue_queue.sv
// Instruction FIFO feeding the execution unit over valid/ready, with flush and perf counters.
module eu_issue_queue
  import eu_issue_pkg::DEFAULT_DEPTH;
  import eu_issue_pkg::DEFAULT_CNT_W;
  import eu_issue_pkg::level_w;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned INSTR_W = eu_issue_pkg::INSTR_W,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [INSTR_W-1:0]       fetch_instr,
  output logic                     fetch_ready,
  input  logic                     flush,
  output logic                     issue_valid,
  output logic [INSTR_W-1:0]       issue_instr,
  input  logic                     issue_ready,
  input  logic                     retire,
  input  logic                     perf_clear,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         issued_count,
  output logic [CNT_W-1:0]         retired_count,
  output logic [CNT_W-1:0]         starve_cycles,
  output logic [CNT_W-1:0]         backpressure_cycles
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = level_w(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level_q;
  logic               push;
  logic               pop;

  // Handshake decode; ready ignores a same-cycle pop so a full queue never accepts.
  always_comb begin
    fetch_ready = (level_q < LVL_W'(DEPTH));
    issue_valid = (level_q != '0) && !flush;
    issue_instr = (level_q != '0) ? mem[rd_ptr] : '0;
    push        = fetch_valid && fetch_ready && !flush;
    pop         = issue_valid && issue_ready;
  end

  assign level = level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  // Storage needs no reset: every read is gated by a non-zero level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= fetch_instr;
    end
  end

  sat_counter #(.W(CNT_W)) u_issued (
    .clk   (clk),
    .reset (reset),
    .clear (perf_clear),
    .inc   (pop),
    .count (issued_count)
  );

  sat_counter #(.W(CNT_W)) u_retired (
    .clk   (clk),
    .reset (reset),
    .clear (perf_clear),
    .inc   (retire),
    .count (retired_count)
  );

  sat_counter #(.W(CNT_W)) u_starve (
    .clk   (clk),
    .reset (reset),
    .clear (perf_clear),
    .inc   (issue_ready && !issue_valid),
    .count (starve_cycles)
  );

  sat_counter #(.W(CNT_W)) u_backpressure (
    .clk   (clk),
    .reset (reset),
    .clear (perf_clear),
    .inc   (issue_valid && !issue_ready),
    .count (backpressure_cycles)
  );

endmodule

// File: tb/tb_eu_issue_queue.sv
// Directed bench for eu_issue_queue: ordering, full/back-pressure, flush, saturation, async reset.
module tb_eu_issue_queue;
  import eu_issue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_valid;
  logic [31:0]       fetch_instr;
  logic              fetch_ready;
  logic              flush;
  logic              issue_valid;
  logic [31:0]       issue_instr;
  logic              issue_ready;
  logic              retire;
  logic              perf_clear;
  logic [2:0]        level;
  logic [CNT_W-1:0]  issued_count;
  logic [CNT_W-1:0]  retired_count;
  logic [CNT_W-1:0]  starve_cycles;
  logic [CNT_W-1:0]  backpressure_cycles;

  int checks   = 0;
  int failures = 0;

  eu_issue_queue #(.DEPTH(DEPTH), .INSTR_W(32), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .fetch_valid         (fetch_valid),
    .fetch_instr         (fetch_instr),
    .fetch_ready         (fetch_ready),
    .flush               (flush),
    .issue_valid         (issue_valid),
    .issue_instr         (issue_instr),
    .issue_ready         (issue_ready),
    .retire              (retire),
    .perf_clear          (perf_clear),
    .level               (level),
    .issued_count        (issued_count),
    .retired_count       (retired_count),
    .starve_cycles       (starve_cycles),
    .backpressure_cycles (backpressure_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_perf();
    perf_clear = 1'b1;
    step();
    perf_clear = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL rst_issue_valid got=%b exp=0", issue_valid); end
    checks++; if (issue_instr !== 32'h0) begin failures++; $display("FAIL rst_issue_instr got=%h exp=0", issue_instr); end
    checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL rst_fetch_ready got=%b exp=1", fetch_ready); end
    checks++; if (issued_count !== 16'd0) begin failures++; $display("FAIL rst_issued got=%0d exp=0", issued_count); end
    step();
    reset = 1'b0;
    issue_ready = 1'b1;
    repeat (5) step();
    checks++; if (starve_cycles !== 16'd5) begin failures++; $display("FAIL idle_starve got=%0d exp=5", starve_cycles); end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL idle_issue_valid got=%b exp=0", issue_valid); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL idle_level got=%0d exp=0", level); end
    checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL idle_fetch_ready got=%b exp=1", fetch_ready); end
    issue_ready = 1'b0;
  endtask

  task automatic test_in_order();
    clear_perf();
    issue_ready = 1'b1;
    fetch_valid = 1'b1;
    fetch_instr = MOV_AL_01;
    #1;
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL no_bypass got=%b exp=0", issue_valid); end
    step();
    checks++; if (issue_instr !== MOV_AL_01) begin failures++; $display("FAIL order_w0 got=%h exp=%h", issue_instr, MOV_AL_01); end
    checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL order_valid got=%b exp=1", issue_valid); end
    fetch_instr = MOV_AX_1234;
    step();
    checks++; if (issue_instr !== MOV_AX_1234) begin failures++; $display("FAIL order_w1 got=%h exp=%h", issue_instr, MOV_AX_1234); end
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL order_level_pp got=%0d exp=1", level); end
    fetch_instr = MOV_CX_1256;
    step();
    checks++; if (issue_instr !== MOV_CX_1256) begin failures++; $display("FAIL order_w2 got=%h exp=%h", issue_instr, MOV_CX_1256); end
    fetch_valid = 1'b0;
    step();
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL order_level_end got=%0d exp=0", level); end
    checks++; if (issued_count !== 16'd3) begin failures++; $display("FAIL order_issued got=%0d exp=3", issued_count); end
    issue_ready = 1'b0;
  endtask

  task automatic test_full_backpressure();
    logic [31:0] w [5];
    clear_perf();
    issue_ready = 1'b0;
    fetch_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w[i] = 32'hA5A5_0000 | 32'(i);
      fetch_instr = w[i];
      #1;
      checks++;
      if (fetch_ready !== (i < 4)) begin
        failures++; $display("FAIL full_ready_%0d got=%b exp=%b", i, fetch_ready, (i < 4));
      end
      checks++;
      if (backpressure_cycles !== 16'((i == 0) ? 0 : i - 1)) begin
        failures++; $display("FAIL bp_step_%0d got=%0d exp=%0d", i, backpressure_cycles, (i == 0) ? 0 : i - 1);
      end
      step();
    end
    fetch_valid = 1'b0;
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", level); end
    checks++; if (backpressure_cycles !== 16'd4) begin failures++; $display("FAIL full_bp got=%0d exp=4", backpressure_cycles); end
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (issue_instr !== w[k]) begin
        failures++; $display("FAIL drain_w%0d got=%h exp=%h", k, issue_instr, w[k]);
      end
      step();
    end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", level); end
    checks++; if (issued_count !== 16'd4) begin failures++; $display("FAIL drain_issued got=%0d exp=4", issued_count); end
    issue_ready = 1'b0;
  endtask

  task automatic test_flush();
    clear_perf();
    issue_ready = 1'b0;
    fetch_valid = 1'b1;
    fetch_instr = MOV_AL_01;
    step();
    fetch_instr = MOV_AX_1234;
    step();
    flush = 1'b1;
    fetch_instr = 32'hDEAD_BEEF;
    issue_ready = 1'b1;
    #1;
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", issue_valid); end
    step();
    flush = 1'b0;
    fetch_valid = 1'b0;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
    checks++; if (issue_instr !== 32'h0) begin failures++; $display("FAIL flush_instr got=%h exp=0", issue_instr); end
    checks++; if (issued_count !== 16'd0) begin failures++; $display("FAIL flush_issued got=%0d exp=0", issued_count); end
    fetch_valid = 1'b1;
    fetch_instr = MOV_CX_1256;
    step();
    fetch_valid = 1'b0;
    checks++; if (issue_instr !== MOV_CX_1256) begin failures++; $display("FAIL post_flush_head got=%h exp=%h", issue_instr, MOV_CX_1256); end
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL post_flush_level got=%0d exp=1", level); end
    step();
    checks++; if (issued_count !== 16'd1) begin failures++; $display("FAIL post_flush_issued got=%0d exp=1", issued_count); end
    issue_ready = 1'b0;
  endtask

  task automatic test_retire_saturation();
    clear_perf();
    issue_ready = 1'b0;
    retire = 1'b1;
    repeat (65534) step();
    checks++; if (retired_count !== 16'hFFFE) begin failures++; $display("FAIL retire_pre_sat got=%h exp=fffe", retired_count); end
    step();
    checks++; if (retired_count !== 16'hFFFF) begin failures++; $display("FAIL retire_sat got=%h exp=ffff", retired_count); end
    repeat (4) step();
    checks++; if (retired_count !== 16'hFFFF) begin failures++; $display("FAIL retire_hold got=%h exp=ffff", retired_count); end
    perf_clear = 1'b1;
    issue_ready = 1'b1;
    step();
    perf_clear = 1'b0;
    retire = 1'b0;
    issue_ready = 1'b0;
    checks++; if (retired_count !== 16'd0) begin failures++; $display("FAIL clr_retired got=%0d exp=0", retired_count); end
    checks++; if (starve_cycles !== 16'd0) begin failures++; $display("FAIL clr_starve got=%0d exp=0", starve_cycles); end
    checks++; if (issued_count !== 16'd0) begin failures++; $display("FAIL clr_issued got=%0d exp=0", issued_count); end
    checks++; if (backpressure_cycles !== 16'd0) begin failures++; $display("FAIL clr_bp got=%0d exp=0", backpressure_cycles); end
  endtask

  task automatic test_async_reset();
    clear_perf();
    issue_ready = 1'b0;
    fetch_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_instr = 32'h5A00_0000 | 32'(i);
      step();
    end
    fetch_valid = 1'b0;
    issue_ready = 1'b1;
    step();
    checks++; if (level !== 3'd3) begin failures++; $display("FAIL mid_level got=%0d exp=3", level); end
    checks++; if (issue_instr !== 32'h5A00_0001) begin failures++; $display("FAIL mid_head got=%h exp=5a000001", issue_instr); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL async_level got=%0d exp=0", level); end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", issue_valid); end
    checks++; if (issue_instr !== 32'h0) begin failures++; $display("FAIL async_instr got=%h exp=0", issue_instr); end
    checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL async_ready got=%b exp=1", fetch_ready); end
    checks++; if (issued_count !== 16'd0) begin failures++; $display("FAIL async_issued got=%0d exp=0", issued_count); end
    checks++; if (backpressure_cycles !== 16'd0) begin failures++; $display("FAIL async_bp got=%0d exp=0", backpressure_cycles); end
    step();
    step();
    reset = 1'b0;
    issue_ready = 1'b0;
    step();
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL post_rst_level got=%0d exp=0", level); end
  endtask

  initial begin
    reset       = 1'b1;
    fetch_valid = 1'b0;
    fetch_instr = NOP_WORD;
    flush       = 1'b0;
    issue_ready = 1'b0;
    retire      = 1'b0;
    perf_clear  = 1'b0;
    step();
    test_reset();
    test_in_order();
    test_full_backpressure();
    test_flush();
    test_retire_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
